// File: rtl/fsm_prob_b_driver.sv
// Drives a 4-state FSM (A..D) toward a requested target state using a shadow model of that FSM.
// Optional {x,y} consistency checking is enabled by defining FSM_PROB_B_DRIVER_CHECK_EN.
module fsm_prob_b_driver (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic [1:0] req_state,
  output logic       req_ready,
  output logic       i,
  output logic       j,
  input  logic       x,
  input  logic       y,
  output logic       done,
  output logic       err
);

  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_A = SW'(0);
  localparam logic [SW-1:0] ST_B = SW'(1);
  localparam logic [SW-1:0] ST_C = SW'(2);
  localparam logic [SW-1:0] ST_D = SW'(3);

  typedef enum logic {
    CTL_IDLE = 1'b0,
    CTL_BUSY = 1'b1
  } ctl_e;

  ctl_e          ctl_q, ctl_d;
  logic [SW-1:0] s_q, s_d;
  logic [SW-1:0] t_q, t_d;

  // Transition function of the driven FSM, mirrored so S tracks it edge for edge
  function automatic logic [SW-1:0] fsm_next(input logic [SW-1:0] s, input logic ii, input logic jj);
    logic [SW-1:0] n;
    n = s;
    case (s)
      ST_A:    n = ii ? ST_B : ST_A;
      ST_B:    n = ii ? ST_C : ST_D;
      ST_C:    n = ii ? ST_B : (jj ? ST_C : ST_D);
      default: n = ii ? ST_D : (jj ? ST_C : ST_A);
    endcase
    return n;
  endfunction

  // Input code that keeps the driven FSM where it is (B has no self-loop; it drifts to C)
  function automatic logic [1:0] hold_code(input logic [SW-1:0] s);
    logic [1:0] c;
    c = 2'b00;
    case (s)
      ST_A:    c = 2'b00;
      ST_B:    c = 2'b10;
      ST_C:    c = 2'b01;
      default: c = 2'b10;
    endcase
    return c;
  endfunction

  // First hop of a shortest path from s to t (s != t)
  function automatic logic [1:0] hop_code(input logic [SW-1:0] s, input logic [SW-1:0] t);
    logic [1:0] c;
    c = 2'b00;
    case (s)
      ST_A:    c = 2'b10;
      ST_B:    c = (t == ST_C) ? 2'b10 : 2'b00;
      ST_C:    c = (t == ST_B) ? 2'b10 : 2'b00;
      default: c = (t == ST_C) ? 2'b01 : 2'b00;
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl_q <= CTL_IDLE;
      s_q   <= ST_A;
      t_q   <= ST_A;
    end else begin
      ctl_q <= ctl_d;
      s_q   <= s_d;
      t_q   <= t_d;
    end
  end

  // Next-state logic
  always_comb begin
    ctl_d = ctl_q;
    t_d   = t_q;
    s_d   = fsm_next(s_q, i, j);
    case (ctl_q)
      CTL_IDLE: begin
        if (req_valid) begin
          t_d   = req_state;
          ctl_d = CTL_BUSY;
        end
      end
      default: begin
        if (s_q == t_q) ctl_d = CTL_IDLE;
      end
    endcase
  end

  // Output logic: stimulus is combinational from S and T so it lands on the same edge
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    {i, j}    = hold_code(s_q);
    case (ctl_q)
      CTL_IDLE: req_ready = 1'b1;
      default: begin
        if (s_q == t_q) done   = 1'b1;
        else            {i, j} = hop_code(s_q, t_q);
      end
    endcase
  end

`ifdef FSM_PROB_B_DRIVER_CHECK_EN
  // Expected {x,y} per state; C and D share a code
  function automatic logic [1:0] exp_xy(input logic [SW-1:0] s);
    logic [1:0] c;
    c = 2'b10;
    case (s)
      ST_A:    c = 2'b11;
      ST_B:    c = 2'b01;
      default: c = 2'b10;
    endcase
    return c;
  endfunction

  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       err_q <= 1'b0;
    else if ({x, y} != exp_xy(s_q))  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_xy;
  assign unused_xy = x ^ y;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_prob_b_driver.sv
// Scoreboard bench for fsm_prob_b_driver with a behavioural model of the driven FSM.
module tb_fsm_prob_b_driver;

  localparam logic [1:0] SA = 2'd0;
  localparam logic [1:0] SB = 2'd1;
  localparam logic [1:0] SC = 2'd2;
  localparam logic [1:0] SD = 2'd3;

`ifdef FSM_PROB_B_DRIVER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]      tgt;
    logic [2:0]      len;
    logic [3:0][1:0] seq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_state = 2'd0;
  logic       req_ready, i, j, x, y, done, err;

  logic [1:0] m_s;
  logic       x_force = 1'b0;

  int total = 0;
  int bad   = 0;

  exp_t sb_q[$];
  exp_t cur;
  logic have = 1'b0;
  int   idx  = 0;

  always #5 clk = ~clk;

  fsm_prob_b_driver dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_state (req_state),
    .req_ready (req_ready),
    .i         (i),
    .j         (j),
    .x         (x),
    .y         (y),
    .done      (done),
    .err       (err)
  );

  // Driven FSM
  function automatic logic [1:0] m_next(input logic [1:0] s, input logic ii, input logic jj);
    case (s)
      SA:      return ii ? SB : SA;
      SB:      return ii ? SC : SD;
      SC:      return ii ? SB : (jj ? SC : SD);
      default: return ii ? SD : (jj ? SC : SA);
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_s <= SA;
    else       m_s <= m_next(m_s, i, j);
  end

  assign x = x_force ? 1'b0 : (m_s != SB);
  assign y = (m_s == SA) || (m_s == SB);

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: follows each busy period and checks the {i,j} trace and the done pulse
  always @(negedge clk) begin
    if (!rstn) begin
      have = 1'b0;
    end else begin
      if (!have && !req_ready && sb_q.size() > 0) begin
        cur  = sb_q.pop_front();
        have = 1'b1;
        idx  = 0;
      end
      if (have) begin
        check("path_ij", 8'({i, j}), 8'(cur.seq[idx]));
        if (done) begin
          check("done_latency", 8'(idx), 8'(int'(cur.len) - 1));
          check("done_state", 8'(m_s), 8'(cur.tgt));
          have = 1'b0;
        end else if (idx >= int'(cur.len) - 1) begin
          check("done_missing", 8'(done), 8'd1);
          have = 1'b0;
        end
        idx++;
      end else if (done) begin
        check("done_unexpected", 8'(done), 8'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 8'(req_ready), 8'd1);
  endtask

  task automatic push(input logic [1:0] tgt, input int len,
                      input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
    exp_t e;
    e.tgt    = tgt;
    e.len    = 3'(len);
    e.seq    = '0;
    e.seq[0] = s0;
    e.seq[1] = s1;
    e.seq[2] = s2;
    sb_q.push_back(e);
  endtask

  // Issue one request and wait until the driver is idle again
  task automatic issue(input logic [1:0] tgt, input int len,
                       input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                       input logic hold_valid);
    wait_ready();
    req_valid = 1'b1;
    req_state = tgt;
    push(tgt, len, s0, s1, s2);
    @(posedge clk);
    @(negedge clk);
    if (hold_valid) req_state = SD;
    else            req_valid = 1'b0;
    wait_ready();
    req_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_ready", 8'(req_ready), 8'd1);
    check("rst_ij", 8'({i, j}), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    check("rst_ready", 8'(req_ready), 8'd1);
    check("rst_ij", 8'({i, j}), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    rstn = 1'b1;

    // k=0 at A, then A->C with req_valid held high while busy
    issue(SA, 1, 2'b00, 2'b00, 2'b00, 1'b0);
    issue(SC, 3, 2'b10, 2'b10, 2'b01, 1'b1);
    check("idle_ij_c", 8'({i, j}), 8'b01);
    issue(SA, 3, 2'b00, 2'b00, 2'b00, 1'b0);
    check("err_clean", 8'(err), 8'd0);
    issue(SD, 3, 2'b10, 2'b00, 2'b10, 1'b0);
    issue(SB, 3, 2'b00, 2'b10, 2'b10, 1'b0);
    check("b_drifts_c", 8'({i, j}), 8'b01);
    issue(SA, 3, 2'b00, 2'b00, 2'b00, 1'b0);

    // Reset in the middle of an A->C request
    wait_ready();
    req_valid = 1'b1;
    req_state = SC;
    push(SC, 3, 2'b10, 2'b10, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    reset_pulse();
    issue(SD, 3, 2'b10, 2'b00, 2'b10, 1'b0);
    issue(SA, 2, 2'b00, 2'b00, 2'b00, 1'b0);

    // Output mismatch while S=A
    check("pre_force_err", 8'(err), 8'd0);
    @(negedge clk);
    x_force = 1'b1;
    @(negedge clk);
    check("err_set", 8'(err), 8'(CHK));
    x_force = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 8'(err), 8'(CHK));
    reset_pulse();

    issue(SB, 2, 2'b10, 2'b10, 2'b00, 1'b0);
    check("b_drifts_c2", 8'({i, j}), 8'b01);
    issue(SD, 2, 2'b00, 2'b10, 2'b00, 1'b0);
    issue(SC, 2, 2'b01, 2'b01, 2'b00, 1'b0);
    issue(SC, 1, 2'b01, 2'b00, 2'b00, 1'b0);
    check("final_err", 8'(err), 8'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 8'(sb_q.size()), 8'd0);
    check("sb_idle", 8'(have), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
